// File: rtl/mm2s_pattern_checker.sv
// Checks an MM2S AXI-Stream against an incrementing 32-bit word pattern and a
// fixed tlast cadence, reporting beat, data-error and tlast-error counts.
module mm2s_pattern_checker #(
  parameter int          DATA_W      = 64,
  parameter int unsigned TOTAL_BEATS = 32'd33554432,
  parameter int unsigned BURST_BEATS = 32'd512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [31:0]       beat_count,
  output logic [31:0]       err_count,
  output logic [15:0]       last_err_count,
  output logic [31:0]       first_err_beat
);

  localparam int          LANES      = DATA_W / 32;
  localparam int          BW         = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_BEATS - 1);
  localparam logic [31:0] LAST_BEAT  = 32'(TOTAL_BEATS - 1);
  localparam logic [31:0] NO_ERR     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     beat_count_q, beat_count_d;
  logic [31:0]     err_count_q, err_count_d;
  logic [15:0]     last_err_count_q, last_err_count_d;
  logic [31:0]     first_err_beat_q, first_err_beat_d;
  logic [31:0]     word_q, word_d;
  logic [BW-1:0]   burst_q, burst_d;

  logic [DATA_W-1:0] exp_data;
  logic              handshake;
  logic              last_exp;
  logic              data_mismatch;
  logic              last_mismatch;

  // Expected beat: lane i carries word_q + i, wrapping naturally at 2**32.
  always_comb begin
    exp_data = '0;
    for (int i = 0; i < LANES; i++) begin
      exp_data[32*i +: 32] = word_q + 32'(i);
    end
  end

  assign handshake     = (state_q == RUN) && s_axis_tvalid;
  assign last_exp      = (burst_q == BURST_LAST);
  assign data_mismatch = (s_axis_tdata != exp_data);
  assign last_mismatch = (s_axis_tlast != last_exp);

  always_comb begin
    state_d          = state_q;
    beat_count_d     = beat_count_q;
    err_count_d      = err_count_q;
    last_err_count_d = last_err_count_q;
    first_err_beat_d = first_err_beat_q;
    word_d           = word_q;
    burst_d          = burst_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d          = RUN;
          beat_count_d     = '0;
          err_count_d      = '0;
          last_err_count_d = '0;
          first_err_beat_d = NO_ERR;
          word_d           = '0;
          burst_d          = '0;
        end
      end
      RUN: begin
        if (handshake) begin
          beat_count_d = beat_count_q + 32'd1;
          word_d       = word_q + 32'(LANES);
          burst_d      = last_exp ? '0 : burst_q + BW'(1);
          if (data_mismatch) begin
            if (err_count_q != 32'hFFFF_FFFF) err_count_d = err_count_q + 32'd1;
            // A zero error count means this is the run's first mismatch.
            if (err_count_q == 32'd0) first_err_beat_d = beat_count_q;
          end
          if (last_mismatch && (last_err_count_q != 16'hFFFF)) begin
            last_err_count_d = last_err_count_q + 16'd1;
          end
          if (beat_count_q == LAST_BEAT) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      beat_count_q     <= '0;
      err_count_q      <= '0;
      last_err_count_q <= '0;
      first_err_beat_q <= NO_ERR;
      word_q           <= '0;
      burst_q          <= '0;
    end else begin
      state_q          <= state_d;
      beat_count_q     <= beat_count_d;
      err_count_q      <= err_count_d;
      last_err_count_q <= last_err_count_d;
      first_err_beat_q <= first_err_beat_d;
      word_q           <= word_d;
      burst_q          <= burst_d;
    end
  end

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign s_axis_tready  = (state_q == RUN);
  assign pass           = done && (err_count_q == 32'd0) && (last_err_count_q == 16'd0);
  assign beat_count     = beat_count_q;
  assign err_count      = err_count_q;
  assign last_err_count = last_err_count_q;
  assign first_err_beat = first_err_beat_q;

endmodule

// File: tb/tb_mm2s_pattern_checker.sv
// Directed bench for mm2s_pattern_checker with DATA_W=64, TOTAL_BEATS=16,
// BURST_BEATS=4; expected beat k is {2k+1, 2k} with tlast on every 4th beat.
module tb_mm2s_pattern_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] beat_count;
  logic [31:0] err_count;
  logic [15:0] last_err_count;
  logic [31:0] first_err_beat;

  int checks = 0;
  int passed = 0;

  mm2s_pattern_checker #(
    .DATA_W(64),
    .TOTAL_BEATS(16),
    .BURST_BEATS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .pass(pass),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .beat_count(beat_count),
    .err_count(err_count),
    .last_err_count(last_err_count),
    .first_err_beat(first_err_beat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Presents one beat for a single clock edge; tready is high throughout RUN.
  task automatic applyStimulus(input logic [63:0] data, input logic last);
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    idleCycle();
    start = 1'b0;
  endtask

  task automatic runBeats(input int first, input int last_k, input int corrupt_a,
                          input int corrupt_b, input int last_miss, input int last_spur,
                          input bit gaps);
    logic [63:0] d;
    logic        l;
    for (int k = first; k <= last_k; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        idleCycle();
        checkOutput("gap_beat_count", beat_count, 32'(k));
      end
      d = {32'(2 * k + 1), 32'(2 * k)};
      if (k == corrupt_a) d[31:0] = 32'h0;
      if (k == corrupt_b) d = d ^ 64'h0000_0001_0000_0000;
      l = ((k % 4) == 3);
      if (k == last_miss) l = 1'b0;
      if (k == last_spur) l = 1'b1;
      applyStimulus(d, l);
    end
  endtask

  task automatic checkDone(input string tag, input logic [31:0] exp_pass,
                           input logic [31:0] exp_err, input logic [31:0] exp_last_err,
                           input logic [31:0] exp_first);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), exp_pass);
    checkOutput({tag, "_beat_count"}, beat_count, 32'd16);
    checkOutput({tag, "_err_count"}, err_count, exp_err);
    checkOutput({tag, "_last_err_count"}, 32'(last_err_count), exp_last_err);
    checkOutput({tag, "_first_err_beat"}, first_err_beat, exp_first);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) idleCycle();
    reset = 1'b0;
    idleCycle();

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("rst_beat_count", beat_count, 32'd0);
    checkOutput("rst_err_count", err_count, 32'd0);
    checkOutput("rst_last_err_count", 32'(last_err_count), 32'd0);
    checkOutput("rst_first_err_beat", first_err_beat, 32'hFFFF_FFFF);

    $display("[TB] clean run");
    pulseStart();
    checkOutput("clean_busy", 32'(busy), 32'd1);
    checkOutput("clean_tready", 32'(s_axis_tready), 32'd1);
    runBeats(0, 15, -1, -1, -1, -1, 1'b0);
    checkDone("clean", 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);
    repeat (5) idleCycle();
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_beat_count", beat_count, 32'd16);

    $display("[TB] data corruption run");
    pulseStart();
    checkOutput("restart_beat_count", beat_count, 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    runBeats(0, 15, 5, 9, -1, -1, 1'b0);
    checkDone("corrupt", 32'd0, 32'd2, 32'd0, 32'd5);

    $display("[TB] tlast error run");
    pulseStart();
    checkOutput("restart2_err_count", err_count, 32'd0);
    checkOutput("restart2_first_err", first_err_beat, 32'hFFFF_FFFF);
    runBeats(0, 15, -1, -1, 3, 4, 1'b0);
    checkDone("tlast", 32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF);

    $display("[TB] gapped clean run");
    pulseStart();
    checkOutput("restart3_last_err", 32'(last_err_count), 32'd0);
    runBeats(0, 15, -1, -1, -1, -1, 1'b1);
    checkDone("gaps", 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);

    $display("[TB] reset mid-run");
    pulseStart();
    runBeats(0, 8, -1, -1, -1, -1, 1'b0);
    checkOutput("prereset_beat_count", beat_count, 32'd9);
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("midrst_beat_count", beat_count, 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    pulseStart();
    runBeats(0, 15, -1, -1, -1, -1, 1'b0);
    checkDone("postrst", 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);

    $display("[TB] start during run");
    pulseStart();
    runBeats(0, 4, 2, -1, -1, -1, 1'b0);
    pulseStart();
    checkOutput("midstart_busy", 32'(busy), 32'd1);
    checkOutput("midstart_beat_count", beat_count, 32'd5);
    checkOutput("midstart_err_count", err_count, 32'd1);
    runBeats(5, 15, -1, -1, -1, -1, 1'b0);
    checkDone("midstart", 32'd0, 32'd1, 32'd0, 32'd2);
    pulseStart();
    checkOutput("donestart_err_count", err_count, 32'd0);
    checkOutput("donestart_beat_count", beat_count, 32'd0);
    runBeats(0, 15, -1, -1, -1, -1, 1'b0);
    checkDone("second", 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
